// File: rtl/truth_table_sweeper.sv
// Purpose: sweeps every input combination of one N_IN-input gate, samples its output into a truth-table word, and checks that word against a reference.
// Latency: 2**N_IN*(SETTLE_CYCLES+1)+1 cycles from the accepted start edge to the done cycle.
// Backpressure: none. start is accepted only in IDLE, and abort cancels a running sweep.
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   start, abort        launch a sweep (in IDLE); cancel a sweep (DRIVE/SAMPLE)
//   expected            reference table, latched on an accepted start
//   dut_in / dut_out    combination driven to the gate (MSB = in1) / gate output
//   busy, done          sweep in progress / one-cycle completion pulse
//   truth_table         captured table; combination k lands in bit 2**N_IN-1-k
//   table_valid         truth_table/match/mismatch hold a complete result
//   match, mismatch     table == expected / table ^ expected
module truth_table_sweeper #(
    parameter int N_IN          = 3,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [2**N_IN-1:0]   expected,
    output logic [N_IN-1:0]      dut_in,
    input  logic                 dut_out,
    output logic                 busy,
    output logic                 done,
    output logic [2**N_IN-1:0]   truth_table,
    output logic                 table_valid,
    output logic                 match,
    output logic [2**N_IN-1:0]   mismatch
);

    localparam int W  = 2**N_IN;
    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_RELOAD = CW'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

    state_t            state, state_nxt;
    logic [N_IN-1:0]   dut_in_nxt;
    logic [CW-1:0]     cnt, cnt_nxt;
    logic [W-1:0]      exp_q, exp_nxt;
    logic [W-1:0]      tbl_nxt, tbl_smp, mm_nxt;
    logic              valid_nxt, match_nxt;
    logic [N_IN-1:0]   bitpos;

    // dut_in doubles as the sweep index. Combination k is stored at bit
    // W-1-k, which is simply the bitwise complement of k in N_IN bits.
    always_comb begin
        bitpos           = ~dut_in;
        tbl_smp          = truth_table;
        tbl_smp[bitpos]  = dut_out;
    end

    assign busy = (state == DRIVE) || (state == SAMPLE);
    assign done = (state == DONE);

    always_comb begin
        state_nxt  = state;
        dut_in_nxt = dut_in;
        cnt_nxt    = cnt;
        exp_nxt    = exp_q;
        tbl_nxt    = truth_table;
        valid_nxt  = table_valid;
        match_nxt  = match;
        mm_nxt     = mismatch;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    state_nxt  = DRIVE;
                    dut_in_nxt = '0;
                    cnt_nxt    = CNT_RELOAD;
                    exp_nxt    = expected;
                    tbl_nxt    = '0;
                    valid_nxt  = 1'b0;
                    match_nxt  = 1'b0;
                    mm_nxt     = '0;
                end
            end
            DRIVE: begin
                if (abort) begin
                    state_nxt  = IDLE;
                    dut_in_nxt = '0;
                end else if (cnt == '0) begin
                    state_nxt = SAMPLE;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            SAMPLE: begin
                // An abort discards this cycle's sample, and the partial table stays visible.
                if (abort) begin
                    state_nxt  = IDLE;
                    dut_in_nxt = '0;
                end else begin
                    tbl_nxt = tbl_smp;
                    if (&dut_in) begin
                        state_nxt = DONE;
                        valid_nxt = 1'b1;
                        match_nxt = (tbl_smp == exp_q);
                        mm_nxt    = tbl_smp ^ exp_q;
                    end else begin
                        state_nxt  = DRIVE;
                        dut_in_nxt = dut_in + N_IN'(1);
                        cnt_nxt    = CNT_RELOAD;
                    end
                end
            end
            DONE: begin
                state_nxt  = IDLE;
                dut_in_nxt = '0;
            end
            default: begin
                state_nxt  = IDLE;
                dut_in_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            dut_in      <= '0;
            cnt         <= '0;
            exp_q       <= '0;
            truth_table <= '0;
            table_valid <= 1'b0;
            match       <= 1'b0;
            mismatch    <= '0;
        end else begin
            state       <= state_nxt;
            dut_in      <= dut_in_nxt;
            cnt         <= cnt_nxt;
            exp_q       <= exp_nxt;
            truth_table <= tbl_nxt;
            table_valid <= valid_nxt;
            match       <= match_nxt;
            mismatch    <= mm_nxt;
        end
    end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Purpose: directed bench for truth_table_sweeper, covering the NAND(in1,in2) gate at SETTLE=4 and the in3 gate at SETTLE=1.
// Latency: each sweep is checked cycle by cycle against hand-derived timing.
// Backpressure: not applicable. The bench drives start and abort directly.
module tb_truth_table_sweeper;

    logic       clk;
    logic       rst;
    logic       start0, abort0, start1, abort1;
    logic [7:0] expected0, expected1;
    logic [2:0] dut_in0, dut_in1;
    logic       dut_out0, dut_out1;
    logic       busy0, done0, busy1, done1;
    logic [7:0] table0, table1, mismatch0, mismatch1;
    logic       valid0, valid1, match0, match1;

    int total = 0;
    int bad   = 0;

    // Gates under test: NAND(in1,in2), where in1 is the MSB, and a buffer on in3 (the LSB).
    assign dut_out0 = ~(dut_in0[2] & dut_in0[1]);
    assign dut_out1 = dut_in1[0];

    truth_table_sweeper #(.N_IN(3), .SETTLE_CYCLES(4)) u0 (
        .clk(clk), .rst(rst), .start(start0), .abort(abort0), .expected(expected0),
        .dut_in(dut_in0), .dut_out(dut_out0), .busy(busy0), .done(done0),
        .truth_table(table0), .table_valid(valid0), .match(match0), .mismatch(mismatch0)
    );

    truth_table_sweeper #(.N_IN(3), .SETTLE_CYCLES(1)) u1 (
        .clk(clk), .rst(rst), .start(start1), .abort(abort1), .expected(expected1),
        .dut_in(dut_in1), .dut_out(dut_out1), .busy(busy1), .done(done1),
        .truth_table(table1), .table_valid(valid1), .match(match1), .mismatch(mismatch1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full sweep on u0. Cycle 1 is the cycle after the accepting edge.
    // start is re-pulsed in cycles pa/pb/pc to show that it is ignored.
    task automatic sweep(input logic [7:0] exp_v, input logic [7:0] want_tbl,
                         input int pa, input int pb, input int pc);
        int ndone;
        ndone     = 0;
        expected0 = exp_v;
        start0    = 1'b1;
        tick();
        for (int c = 1; c <= 41; c++) begin
            int want_in;
            start0  = (c == pa || c == pb || c == pc);
            want_in = (c <= 40) ? (c - 1) / 5 : 7;
            chk("dut_in", dut_in0, want_in);
            chk("busy", busy0, c <= 40);
            ndone += done0;
            if (c == 41) begin
                chk("done", done0, 1);
                chk("table", table0, want_tbl);
                chk("valid", valid0, 1);
                chk("match", match0, want_tbl == exp_v);
                chk("mismatch", mismatch0, want_tbl ^ exp_v);
            end
            tick();
        end
        start0 = 1'b0;
        chk("done_count", ndone, 1);
    endtask

    initial begin
        int ndone;
        rst = 1'b1;
        start0 = 1'b0; abort0 = 1'b0; expected0 = '0;
        start1 = 1'b0; abort1 = 1'b0; expected1 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy0, 0);
        chk("rst_done", done0, 0);
        chk("rst_dut_in", dut_in0, 0);
        chk("rst_table", table0, 0);
        chk("rst_valid", valid0, 0);
        chk("rst_match", match0, 0);
        chk("rst_mismatch", mismatch0, 0);
        rst = 1'b0;
        tick();

        // NAND sweep with a matching reference, then with a mismatching one.
        sweep(8'hFC, 8'hFC, 0, 0, 0);
        tick();
        sweep(8'hFE, 8'hFC, 0, 0, 0);
        tick();

        // start pulses in DRIVE (cycle 10), SAMPLE (cycle 40) and DONE (cycle 41) are ignored.
        sweep(8'hFC, 8'hFC, 10, 40, 41);
        chk("c42_busy", busy0, 0);
        chk("c42_dut_in", dut_in0, 0);
        chk("c42_valid", valid0, 1);
        tick();
        start0 = 1'b1;                       // cycle 43
        chk("c43_valid", valid0, 1);
        chk("c43_busy", busy0, 0);
        tick();
        start0 = 1'b0;                       // cycle 44 = new sweep, cycle 1
        chk("c44_valid", valid0, 0);
        chk("c44_busy", busy0, 1);
        chk("c44_table", table0, 8'h00);

        // abort in cycle 17, while combination 3 is held. Bits 7..5 are already captured.
        for (int c = 2; c <= 17; c++) tick();
        chk("pre_abort_dut_in", dut_in0, 3);
        abort0 = 1'b1;
        tick();
        abort0 = 1'b0;
        chk("abort_busy", busy0, 0);
        chk("abort_dut_in", dut_in0, 0);
        chk("abort_valid", valid0, 0);
        chk("abort_table", table0, 8'hE0);
        ndone = 0;
        for (int c = 0; c < 60; c++) begin
            ndone += done0;
            tick();
        end
        chk("abort_no_done", ndone, 0);

        // start together with abort in IDLE: abort wins.
        start0 = 1'b1; abort0 = 1'b1;
        tick();
        start0 = 1'b0; abort0 = 1'b0;
        chk("start_abort_busy", busy0, 0);

        // Asynchronous reset in the middle of DRIVE.
        expected0 = 8'hFC;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        for (int c = 2; c <= 7; c++) tick();
        chk("pre_rst_dut_in", dut_in0, 1);
        chk("pre_rst_table", table0, 8'h80);
        #1 rst = 1'b1;
        #1;
        chk("arst_busy", busy0, 0);
        chk("arst_dut_in", dut_in0, 0);
        chk("arst_table", table0, 0);
        chk("arst_valid", valid0, 0);
        chk("arst_done", done0, 0);
        #1 rst = 1'b0;
        tick();
        sweep(8'hFC, 8'hFC, 0, 0, 0);

        // SETTLE=1 instance with gate = in3: each combination is held for 2 cycles.
        expected1 = 8'h55;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int c = 1; c <= 17; c++) begin
            chk("s1_dut_in", dut_in1, (c <= 16) ? (c - 1) / 2 : 7);
            chk("s1_done", done1, c == 17);
            if (c == 17) begin
                chk("s1_table", table1, 8'h55);
                chk("s1_match", match1, 1);
                chk("s1_valid", valid1, 1);
            end
            tick();
        end
        chk("s1_idle_busy", busy1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
- Sequencer that characterises one combinational N-input, 1-output logic gate (the DUT gate).
- Drives every input combination onto the gate in ascending order and waits a programmable settle time at each one.
- Samples the gate output into a 2^N-bit truth-table word in the team's hex naming order, then compares the word against an expected value.
- Sits between a test/config host and a gate instance. It is the scheduler that exercises and verifies gates such as the 0xFC family.

Parameters:
- N_IN, 3, number of gate inputs (1..6).
- SETTLE_CYCLES, 4, cycles each combination is held before sampling (>=1).

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begin a sweep; honoured only in IDLE.
- abort  input  1  cancel the sweep in progress.
- expected  input  2^N_IN  reference truth table; sampled on an accepted start.
- dut_in  output  N_IN  combination driven to the gate; dut_in[N_IN-1] = in1 (MSB).
- dut_out  input  1  gate output.
- busy  output  1  high from the cycle after an accepted start until the sweep ends.
- done  output  1  one-cycle pulse when the sweep completes.
- table  output  2^N_IN  captured truth table.
- table_valid  output  1  table/match/mismatch hold a complete result.
- match  output  1  table == captured expected.
- mismatch  output  2^N_IN  table XOR captured expected.

Behaviour:
- Reset, asserted at any time including mid-sweep: state=IDLE; dut_in=0, busy=0, done=0, table=0, table_valid=0, match=0, mismatch=0. All effects are immediate and asynchronous.
- Bit order: the result for combination k (k = dut_in value) goes to table bit (2^N_IN-1-k). Combination 0 is the MSB, so a NAND(in1,in2) gate yields 8'hFC.
- States:
  - IDLE: start=1 and abort=0 → DRIVE. On the transition: index=0, dut_in=0, settle counter=SETTLE_CYCLES-1, table=0, table_valid=0, match=0, mismatch=0, expected latched, busy=1.
  - DRIVE: dut_in held. When the counter reaches 0 → SAMPLE; otherwise the counter decrements. Duration is SETTLE_CYCLES cycles.
  - SAMPLE: one cycle, dut_in still held. On its closing edge, dut_out is written to the table bit for the current index.
    - If index < 2^N_IN-1: index+1, dut_in=index+1, counter reloaded → DRIVE.
    - Otherwise → DONE.
  - DONE: one cycle. done=1, busy=0, table_valid=1, match and mismatch computed from the final table. Then → IDLE.
- Latency: from an accepted start edge to the done cycle is 2^N_IN*(SETTLE_CYCLES+1)+1 cycles. With the defaults this is 41 cycles; busy is high for 40 of them.
- start while busy, or during the DONE cycle: ignored. A new sweep needs start in IDLE.
- abort=1 in DRIVE or SAMPLE: next state IDLE, busy=0, dut_in=0, no done pulse, table_valid stays 0. The partial table remains visible. Abort has priority over a same-cycle sample.
- abort in IDLE or DONE: no effect. start and abort high together in IDLE: abort wins and no sweep starts.
- The index never wraps past 2^N_IN-1. table, match and mismatch hold their values until the next accepted start or reset.
- dut_in changes only on SAMPLE→DRIVE, IDLE→DRIVE, abort and reset. It returns to 0 on entry to IDLE.

Test Plan:
- N_IN=3, SETTLE=4, DUT = ~(in1&in2), expected=8'hFC, one start pulse → dut_in steps 0..7, each held 5 cycles; done at cycle 41; table=8'hFC, match=1, mismatch=0.
- Same DUT, expected=8'hFE → table=8'hFC, match=0, mismatch=8'h02, table_valid=1.
- start pulsed at cycles 10 and 40 of a sweep → only one done pulse, at cycle 41; a new start at cycle 43 launches a second sweep, and table_valid drops the cycle after that start.
- abort at cycle 17 (combination 3) → busy=0 and dut_in=0 next cycle, no done, table_valid=0; table bits 7..5 are already captured.
- rst asserted asynchronously mid-DRIVE → all outputs read their reset values before the next clk edge; a subsequent start sweeps normally.
- SETTLE_CYCLES=1, DUT = in3, expected=8'h55 → each combination held 2 cycles; done at cycle 17; table=8'h55, match=1.
